// File: rtl/vector_pack.sv
// vector_pack: assembles TILING signed elements per beat into one
// VECTOR_LEN-wide vector with signed width conversion and a sticky error flag.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready beat input;
// vec/vec_valid/vec_ready vector output; error = range error of current vector.
// Build option: VECTOR_PACK_SATURATE_EN clamps out-of-range narrowed elements.
module vector_pack #(
    parameter int VECTOR_LEN     = 5,
    parameter int IN_CELL_WIDTH  = 8,
    parameter int OUT_CELL_WIDTH = 8,
    parameter int TILING         = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [TILING*IN_CELL_WIDTH-1:0]      in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [VECTOR_LEN*OUT_CELL_WIDTH-1:0] vec,
    output logic                                 vec_valid,
    input  logic                                 vec_ready,
    output logic                                 error
);

    // Counter must reach VECTOR_LEN+TILING-1 after a partial final beat.
    localparam int CNT_W = $clog2(VECTOR_LEN + TILING);

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [OUT_CELL_WIDTH-1:0] buf_q [VECTOR_LEN];
    logic [OUT_CELL_WIDTH-1:0] buf_d [VECTOR_LEN];

    logic [OUT_CELL_WIDTH-1:0] lane_conv [TILING];
    logic [TILING-1:0]         lane_err;

    for (genvar k = 0; k < TILING; k++) begin : g_lane
        logic [IN_CELL_WIDTH-1:0] raw;
        assign raw = in_data[k*IN_CELL_WIDTH +: IN_CELL_WIDTH];

        if (OUT_CELL_WIDTH > IN_CELL_WIDTH) begin : g_widen
            assign lane_conv[k] = {{(OUT_CELL_WIDTH-IN_CELL_WIDTH){raw[IN_CELL_WIDTH-1]}}, raw};
            assign lane_err[k]  = 1'b0;
        end else if (OUT_CELL_WIDTH == IN_CELL_WIDTH) begin : g_same
            assign lane_conv[k] = raw;
            assign lane_err[k]  = 1'b0;
        end else begin : g_narrow
            // In range iff the dropped bits and the new sign bit all agree.
            logic [IN_CELL_WIDTH-OUT_CELL_WIDTH:0] top;
            assign top         = raw[IN_CELL_WIDTH-1:OUT_CELL_WIDTH-1];
            assign lane_err[k] = ~((&top) | ~(|top));
`ifdef VECTOR_PACK_SATURATE_EN
            localparam logic [OUT_CELL_WIDTH-1:0] SAT_MIN =
                OUT_CELL_WIDTH'(1) << (OUT_CELL_WIDTH - 1);
            localparam logic [OUT_CELL_WIDTH-1:0] SAT_MAX = ~SAT_MIN;
            assign lane_conv[k] = !lane_err[k]         ? raw[OUT_CELL_WIDTH-1:0] :
                                  raw[IN_CELL_WIDTH-1] ? SAT_MIN : SAT_MAX;
`else
            assign lane_conv[k] = raw[OUT_CELL_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int j = 0; j < VECTOR_LEN; j++) buf_q[j] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int j = 0; j < VECTOR_LEN; j++) buf_q[j] <= buf_d[j];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        for (int j = 0; j < VECTOR_LEN; j++) buf_d[j] = buf_q[j];

        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    // Lanes past the end of the vector are dropped entirely,
                    // so unknowns on them cannot reach the buffer or error.
                    for (int k = 0; k < TILING; k++) begin
                        if (int'(cnt_q) + k < VECTOR_LEN) err_d = err_d | lane_err[k];
                    end
                    for (int j = 0; j < VECTOR_LEN; j++) begin
                        for (int k = 0; k < TILING; k++) begin
                            if (int'(cnt_q) + k == j) buf_d[j] = lane_conv[k];
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(TILING);
                    if (int'(cnt_q) >= VECTOR_LEN - TILING) state_d = DONE;
                end
            end
            DONE: begin
                if (vec_ready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    for (int j = 0; j < VECTOR_LEN; j++) buf_d[j] = '0;
                end
            end
        endcase
    end

    assign in_ready  = (state_q == FILL);
    assign vec_valid = (state_q == DONE);
    assign error     = err_q;

    for (genvar j = 0; j < VECTOR_LEN; j++) begin : g_vec
        assign vec[j*OUT_CELL_WIDTH +: OUT_CELL_WIDTH] = buf_q[j];
    end

endmodule

// File: tb/tb_vector_pack.sv
// tb_vector_pack: bench for vector_pack across four width/tiling configs.
// Table vectors, hand-written corner sequences and a random model check.
module tb_vector_pack;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // a: 5 x 8->8, tiling 1
    logic [7:0]  a_data;
    logic        a_valid, a_ready, a_vv, a_vr, a_err;
    logic [39:0] a_vec;
    // b: 5 x 8->4, tiling 2
    logic [15:0] b_data;
    logic        b_valid, b_ready, b_vv, b_vr, b_err;
    logic [19:0] b_vec;
    // c: 5 x 8->4, tiling 1
    logic [7:0]  c_data;
    logic        c_valid, c_ready, c_vv, c_vr, c_err;
    logic [19:0] c_vec;
    // d: 5 x 4->8, tiling 1
    logic [3:0]  d_data;
    logic        d_valid, d_ready, d_vv, d_vr, d_err;
    logic [39:0] d_vec;

    vector_pack #(.VECTOR_LEN(5), .IN_CELL_WIDTH(8), .OUT_CELL_WIDTH(8), .TILING(1)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .vec(a_vec), .vec_valid(a_vv), .vec_ready(a_vr), .error(a_err));
    vector_pack #(.VECTOR_LEN(5), .IN_CELL_WIDTH(8), .OUT_CELL_WIDTH(4), .TILING(2)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .vec(b_vec), .vec_valid(b_vv), .vec_ready(b_vr), .error(b_err));
    vector_pack #(.VECTOR_LEN(5), .IN_CELL_WIDTH(8), .OUT_CELL_WIDTH(4), .TILING(1)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .vec(c_vec), .vec_valid(c_vv), .vec_ready(c_vr), .error(c_err));
    vector_pack #(.VECTOR_LEN(5), .IN_CELL_WIDTH(4), .OUT_CELL_WIDTH(8), .TILING(1)) u_d (
        .clk(clk), .rst(rst), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
        .vec(d_vec), .vec_valid(d_vv), .vec_ready(d_vr), .error(d_err));

    typedef struct {
        logic [7:0]  e [5];
        logic [39:0] exp;
    } rec_t;
    rec_t tbl [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push_a(input logic [7:0] d);
        a_valid = 1'b1;
        a_data  = d;
        tick();
    endtask

    task automatic push_c(input logic [7:0] d);
        c_valid = 1'b1;
        c_data  = d;
        tick();
    endtask

    task automatic push_d(input logic [3:0] d);
        d_valid = 1'b1;
        d_data  = d;
        tick();
    endtask

    // Signed conversion by value: range check against the output width,
    // then either clamp or wrap modulo 2^outw.
    function automatic void conv_ref(input int v, input int inw, input int outw,
                                     output int r, output bit e);
        int lo, hi;
        lo = -(1 << (outw - 1));
        hi = (1 << (outw - 1)) - 1;
        e  = (outw < inw) && (v < lo || v > hi);
        r  = v;
        if (e) begin
`ifdef VECTOR_PACK_SATURATE_EN
            r = (v < 0) ? lo : hi;
`else
            r = v & ((1 << outw) - 1);
            if (r > hi) r -= (1 << outw);
`endif
        end
    endfunction

    int         m_el [5];
    int         m_cnt;
    bit         m_done;
    bit         m_err;
    logic [19:0] ev;
    logic [19:0] narrow_exp;

    initial begin
        rst = 1'b1;
        a_data = '0; a_valid = 0; a_vr = 0;
        b_data = '0; b_valid = 0; b_vr = 0;
        c_data = '0; c_valid = 0; c_vr = 0;
        d_data = '0; d_valid = 0; d_vr = 0;

        tbl[0].e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        tbl[0].exp = 40'h05_04_03_02_01;
        tbl[1].e = '{8'hFF, 8'h80, 8'h7F, 8'h00, 8'h55};
        tbl[1].exp = 40'h55_00_7F_80_FF;
        tbl[2].e = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h01};
        tbl[2].exp = 40'h01_3C_C3_5A_A5;

        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", 64'(a_ready), 64'(1));
        chk("reset_vec_valid", 64'(a_vv), 64'(0));
        chk("reset_vec", 64'(a_vec), 64'(0));
        chk("reset_error", 64'(a_err), 64'(0));
        chk("reset_b_vec", 64'(b_vec), 64'(0));

        // Table-driven back-to-back assembly
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 5; b++) begin
                push_a(tbl[i].e[b]);
                if (b < 4) begin
                    chk("tbl_fill_ready", 64'(a_ready), 64'(1));
                    chk("tbl_fill_valid", 64'(a_vv), 64'(0));
                end
            end
            a_valid = 1'b0;
            chk("tbl_vec_valid", 64'(a_vv), 64'(1));
            chk("tbl_vec", 64'(a_vec), 64'(tbl[i].exp));
            chk("tbl_error", 64'(a_err), 64'(0));
            chk("tbl_in_ready_low", 64'(a_ready), 64'(0));
            a_vr = 1'b1;
            tick();
            a_vr = 1'b0;
            chk("tbl_release_valid", 64'(a_vv), 64'(0));
            chk("tbl_release_vec", 64'(a_vec), 64'(0));
            chk("tbl_release_ready", 64'(a_ready), 64'(1));
        end

        // Backpressure with a beat held during DONE
        for (int b = 0; b < 5; b++) push_a(8'(10 + b));
        a_valid = 1'b1;
        a_data  = 8'h09;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 64'(a_vv), 64'(1));
            chk("bp_vec_stable", 64'(a_vec), 64'(40'h0E_0D_0C_0B_0A));
            chk("bp_in_ready", 64'(a_ready), 64'(0));
        end
        a_vr = 1'b1;
        tick();
        a_vr = 1'b0;
        chk("bp_hs_valid", 64'(a_vv), 64'(0));
        chk("bp_hs_ready", 64'(a_ready), 64'(1));
        chk("bp_hs_vec", 64'(a_vec), 64'(0));
        tick();
        chk("bp_held_beat", 64'(a_vec), 64'(40'h09));
        push_a(8'h33);
        a_valid = 1'b0;
        chk("bp_second_beat", 64'(a_vec), 64'(40'h33_09));

        // Reset mid-fill
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", 64'(a_ready), 64'(1));
        chk("midrst_valid", 64'(a_vv), 64'(0));
        chk("midrst_vec", 64'(a_vec), 64'(0));
        chk("midrst_error", 64'(a_err), 64'(0));
        for (int b = 0; b < 5; b++) push_a(8'(21 + b));
        a_valid = 1'b0;
        chk("postrst_valid", 64'(a_vv), 64'(1));
        chk("postrst_vec", 64'(a_vec), 64'(40'h19_18_17_16_15));
        chk("postrst_error", 64'(a_err), 64'(0));
        a_vr = 1'b1;
        tick();
        a_vr = 1'b0;

        // Partial final beat, lane 1 of last beat unknown
        b_valid = 1'b1;
        b_data  = 16'h0201;
        tick();
        chk("part_b1_ready", 64'(b_ready), 64'(1));
        chk("part_b1_valid", 64'(b_vv), 64'(0));
        b_data = 16'h0403;
        tick();
        chk("part_b2_ready", 64'(b_ready), 64'(1));
        chk("part_b2_valid", 64'(b_vv), 64'(0));
        b_data = 16'hxx05;
        tick();
        b_valid = 1'b0;
        chk("part_valid", 64'(b_vv), 64'(1));
        chk("part_vec", 64'(b_vec), 64'(20'h54321));
        chk("part_error", 64'(b_err), 64'(0));
        chk("part_in_ready", 64'(b_ready), 64'(0));
        b_vr = 1'b1;
        tick();
        b_vr = 1'b0;
        chk("part_release", 64'(b_vv), 64'(0));

        // Narrowing 8 -> 4
`ifdef VECTOR_PACK_SATURATE_EN
        narrow_exp = 20'h38787;
`else
        narrow_exp = 20'h37887;
`endif
        push_c(8'h07);
        push_c(8'hF8);
        push_c(8'h08);
        push_c(8'hF7);
        push_c(8'h03);
        c_valid = 1'b0;
        chk("narrow_valid", 64'(c_vv), 64'(1));
        chk("narrow_vec", 64'(c_vec), 64'(narrow_exp));
        chk("narrow_error", 64'(c_err), 64'(1));
        c_vr = 1'b1;
        tick();
        c_vr = 1'b0;
        chk("narrow_err_clear", 64'(c_err), 64'(0));
        push_c(8'h01);
        push_c(8'hFF);
        push_c(8'h00);
        push_c(8'h02);
        push_c(8'hFE);
        c_valid = 1'b0;
        chk("narrow_ok_vec", 64'(c_vec), 64'(20'hE20F1));
        chk("narrow_ok_error", 64'(c_err), 64'(0));
        c_vr = 1'b1;
        tick();
        c_vr = 1'b0;

        // Widening 4 -> 8
        push_d(4'hF);
        push_d(4'h1);
        push_d(4'h7);
        push_d(4'h8);
        push_d(4'h0);
        d_valid = 1'b0;
        chk("widen_valid", 64'(d_vv), 64'(1));
        chk("widen_vec", 64'(d_vec), 64'(40'h00_F8_07_01_FF));
        chk("widen_error", 64'(d_err), 64'(0));
        d_vr = 1'b1;
        tick();
        d_vr = 1'b0;

        // Random traffic on the tiled narrowing instance
        m_cnt  = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
        for (int j = 0; j < 5; j++) m_el[j] = 0;
        for (int c = 0; c < 400; c++) begin
            int v0, v1, r;
            bit e;
            v0 = ($urandom_range(1) == 1) ? int'($urandom_range(15)) - 8
                                          : int'($urandom_range(255)) - 128;
            v1 = ($urandom_range(1) == 1) ? int'($urandom_range(15)) - 8
                                          : int'($urandom_range(255)) - 128;
            b_valid = ($urandom_range(3) != 0);
            b_vr    = ($urandom_range(1) == 1);
            b_data  = {8'(v1), 8'(v0)};
            if (!m_done && b_valid) begin
                for (int k = 0; k < 2; k++) begin
                    if (m_cnt + k < 5) begin
                        conv_ref((k == 0) ? v0 : v1, 8, 4, r, e);
                        m_el[m_cnt + k] = r;
                        m_err = m_err | e;
                    end
                end
                m_cnt += 2;
                if (m_cnt >= 5) m_done = 1'b1;
            end else if (m_done && b_vr) begin
                m_done = 1'b0;
                m_cnt  = 0;
                m_err  = 1'b0;
                for (int j = 0; j < 5; j++) m_el[j] = 0;
            end
            tick();
            for (int j = 0; j < 5; j++) ev[j*4 +: 4] = 4'(m_el[j]);
            chk("rand_in_ready", 64'(b_ready), 64'(!m_done));
            chk("rand_vec_valid", 64'(b_vv), 64'(m_done));
            chk("rand_vec", 64'(b_vec), 64'(ev));
            chk("rand_error", 64'(b_err), 64'(m_err));
        end
        b_valid = 1'b0;
        b_vr    = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
